// File: rtl/fdiv16_seq.sv
// fdiv16_seq: sequential binary16 divider, result = x / y.
// Restoring radix-2 divider producing one quotient bit per clock, with 13 quotient
// bits followed by a single rounding cycle. Valid/ready handshakes sit on both the
// input and the output, and only one operation is in flight at a time.
// Subnormal operands are flushed to zero and raise no flag.
// Optional macro FDIV16_EARLY_OUT_EN: a divisor whose significand is exactly 1.0
// skips the DIV iterations and goes straight to ROUND.
module fdiv16_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [1:0]  roundmode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic [3:0]  flags
);

   typedef enum logic [1:0] {StIdle, StDiv, StRound, StDone} state_e;

   localparam logic [1:0] RmRz  = 2'b00;
   localparam logic [1:0] RmRne = 2'b01;
   localparam logic [1:0] RmRd  = 2'b10;
   localparam logic [1:0] RmRu  = 2'b11;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [12:0]        quo_q, quo_d;
   logic [11:0]        rem_q, rem_d;
   logic [10:0]        dvs_q, dvs_d;
   logic               sign_q, sign_d;
   logic signed [6:0]  exp_q, exp_d;
   logic [1:0]         rm_q, rm_d;
   logic [15:0]        result_q, result_d;
   logic [3:0]         flags_q, flags_d;

   // Operand fields and classification
   logic [4:0] xe, ye;
   logic [9:0] xm, ym;
   logic       x_zero, x_inf, x_nan, y_zero, y_inf, y_nan, special, op_sign;
   logic [15:0] spec_res;
   logic [3:0]  spec_flags;
   logic signed [6:0] exp_init;

   assign xe       = x[14:10];
   assign xm       = x[9:0];
   assign ye       = y[14:10];
   assign ym       = y[9:0];
   assign x_zero   = (xe == 5'd0);
   assign y_zero   = (ye == 5'd0);
   assign x_inf    = (xe == 5'h1f) && (xm == 10'd0);
   assign y_inf    = (ye == 5'h1f) && (ym == 10'd0);
   assign x_nan    = (xe == 5'h1f) && (xm != 10'd0);
   assign y_nan    = (ye == 5'h1f) && (ym != 10'd0);
   assign special  = x_zero | x_inf | x_nan | y_zero | y_inf | y_nan;
   assign op_sign  = x[15] ^ y[15];
   // Modulo-128 arithmetic gives the correct two's-complement biased exponent
   assign exp_init = 7'(xe) - 7'(ye) + 7'd15;

   // Special-operand result, resolved in priority order at accept time
   always_comb begin
      spec_res   = {op_sign, 15'h0000};
      spec_flags = 4'b0000;
      if (x_nan || y_nan) begin
         spec_res = 16'h7e00;
      end else if ((x_zero && y_zero) || (x_inf && y_inf)) begin
         spec_res   = 16'h7e00;
         spec_flags = 4'b1000;
      end else if (y_zero) begin
         spec_res = {op_sign, 5'h1f, 10'h000};
      end else if (x_zero || y_inf) begin
         spec_res = {op_sign, 15'h0000};
      end else if (x_inf) begin
         spec_res = {op_sign, 5'h1f, 10'h000};
      end
   end

   // One restoring iteration: compare, conditionally subtract, shift
   logic        quo_bit;
   logic [11:0] rem_sub, rem_next;
   logic [12:0] quo_next;

   always_comb begin
      quo_bit  = (rem_q >= {1'b0, dvs_q});
      rem_sub  = quo_bit ? (rem_q - {1'b0, dvs_q}) : rem_q;
      rem_next = {rem_sub[10:0], 1'b0};
      quo_next = {quo_q[11:0], quo_bit};
   end

   // Normalise, round and detect overflow/underflow from the finished quotient
   logic [10:0]       sig;
   logic              guard, sticky, inc, inexact, inf_sel;
   logic [11:0]       sig_rnd;
   logic [9:0]        frac;
   logic signed [6:0] exp_adj, exp_fin;
   logic [15:0]       rnd_res;
   logic [3:0]        rnd_flags;

   always_comb begin
      if (quo_q[12]) begin
         sig     = quo_q[12:2];
         guard   = quo_q[1];
         sticky  = quo_q[0] | (|rem_q);
         exp_adj = exp_q;
      end else begin
         sig     = quo_q[11:1];
         guard   = quo_q[0];
         sticky  = |rem_q;
         exp_adj = exp_q - 7'sd1;
      end
      inexact = guard | sticky;
      unique case (rm_q)
         RmRne:   inc = guard & (sticky | sig[0]);
         RmRu:    inc = inexact & ~sign_q;
         RmRd:    inc = inexact & sign_q;
         default: inc = 1'b0;
      endcase
      sig_rnd = {1'b0, sig} + {11'd0, inc};
      if (sig_rnd[11]) begin
         exp_fin = exp_adj + 7'sd1;
         frac    = 10'd0;
      end else begin
         exp_fin = exp_adj;
         frac    = sig_rnd[9:0];
      end
      inf_sel = (rm_q == RmRne) || ((rm_q == RmRu) && !sign_q) || ((rm_q == RmRd) && sign_q);
      if (exp_fin >= 7'sd31) begin
         rnd_res   = inf_sel ? {sign_q, 5'h1f, 10'h000} : {sign_q, 15'h7bff};
         rnd_flags = 4'b0101;
      end else if (exp_fin <= 7'sd0) begin
         rnd_res   = {sign_q, 15'h0000};
         rnd_flags = 4'b0011;
      end else begin
         rnd_res   = {sign_q, exp_fin[4:0], frac};
         rnd_flags = {3'b000, inexact};
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      rm_d     = rm_q;
      result_d = result_q;
      flags_d  = flags_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sign_d = op_sign;
               rm_d   = roundmode;
               if (special) begin
                  result_d = spec_res;
                  flags_d  = spec_flags;
                  state_d  = StDone;
               end else begin
                  exp_d   = exp_init;
                  rem_d   = {2'b01, xm};
                  dvs_d   = {1'b1, ym};
                  quo_d   = 13'd0;
                  cnt_d   = 4'd0;
                  state_d = StDiv;
`ifdef FDIV16_EARLY_OUT_EN
                  // Divisor of exactly 1.0: the quotient is the dividend significand
                  if (ym == 10'd0) begin
                     quo_d   = {1'b1, xm, 2'b00};
                     rem_d   = 12'd0;
                     state_d = StRound;
                  end
`endif
               end
            end
         end
         StDiv: begin
            quo_d = quo_next;
            rem_d = rem_next;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd12) state_d = StRound;
         end
         StRound: begin
            result_d = rnd_res;
            flags_d  = rnd_flags;
            state_d  = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         quo_q    <= 13'd0;
         rem_q    <= 12'd0;
         dvs_q    <= 11'd0;
         sign_q   <= 1'b0;
         exp_q    <= 7'sd0;
         rm_q     <= 2'b00;
         result_q <= 16'h0000;
         flags_q  <= 4'b0000;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         rm_q     <= rm_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv16_seq.sv
// Directed self-checking bench for fdiv16_seq.
module tb_fdiv16_seq;

   localparam logic [1:0] RZ  = 2'b00;
   localparam logic [1:0] RNE = 2'b01;
   localparam logic [1:0] RD  = 2'b10;
   localparam logic [1:0] RU  = 2'b11;
   localparam int LatFull = 15;
   localparam int LatSpec = 1;
`ifdef FDIV16_EARLY_OUT_EN
   localparam int LatOne = 2;
`else
   localparam int LatOne = 15;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x, y;
   logic [1:0]  roundmode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  flags;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;

   fdiv16_seq dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .roundmode (roundmode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present operands for one edge, then count edges (accept edge = 1) until out_valid
   task automatic issue(input logic [15:0] xv, input logic [15:0] yv, input logic [1:0] rm);
      x = xv;
      y = yv;
      roundmode = rm;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                         input logic [1:0] rm, input logic [15:0] er, input logic [3:0] ef,
                         input int el);
      issue(xv, yv, rm);
      check({tag, " latency"}, 32'(lat), 32'(el));
      check({tag, " result"}, 32'(result), 32'(er));
      check({tag, " flags"}, 32'(flags), 32'(ef));
      drain(tag);
   endtask

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      x = 16'h0000;
      y = 16'h0000;
      roundmode = RNE;
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", 32'(result), 32'h0000);
      check("reset flags", 32'(flags), 32'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Normal path rounding
      run_op("1/3 rne", 16'h3c00, 16'h4200, RNE, 16'h3555, 4'b0001, LatFull);
      run_op("1/3 ru",  16'h3c00, 16'h4200, RU,  16'h3556, 4'b0001, LatFull);
      run_op("1/3 rz",  16'h3c00, 16'h4200, RZ,  16'h3555, 4'b0001, LatFull);
      run_op("-1/3 rd", 16'hbc00, 16'h4200, RD,  16'hb556, 4'b0001, LatFull);
      run_op("-1/3 ru", 16'hbc00, 16'h4200, RU,  16'hb555, 4'b0001, LatFull);

      // Overflow and underflow
      run_op("ovf rne", 16'h7bff, 16'h3400, RNE, 16'h7c00, 4'b0101, LatOne);
      run_op("ovf rz",  16'h7bff, 16'h3400, RZ,  16'h7bff, 4'b0101, LatOne);
      run_op("unf rne", 16'h0400, 16'h7800, RNE, 16'h0000, 4'b0011, LatOne);

      // Special operands
      run_op("0/0",     16'h0000, 16'h0000, RNE, 16'h7e00, 4'b1000, LatSpec);
      run_op("-1/0",    16'hbc00, 16'h0000, RNE, 16'hfc00, 4'b0000, LatSpec);
      run_op("nan/1",   16'h7e01, 16'h3c00, RNE, 16'h7e00, 4'b0000, LatSpec);
      run_op("inf/inf", 16'h7c00, 16'h7c00, RNE, 16'h7e00, 4'b1000, LatSpec);
      run_op("1/inf",   16'h3c00, 16'h7c00, RNE, 16'h0000, 4'b0000, LatSpec);
      run_op("inf/-2",  16'h7c00, 16'hc000, RNE, 16'hfc00, 4'b0000, LatSpec);

      // 2/1 with in_valid held high while busy: must be ignored
      x = 16'h4000;
      y = 16'h3c00;
      roundmode = RNE;
      in_valid = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      for (int i = 0; i < 3; i++) begin
         check("busy in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("2/1 latency", 32'(lat), 32'(LatOne));
      check("2/1 result", 32'(result), 32'h4000);
      check("2/1 flags", 32'(flags), 32'h0);
      drain("2/1");
      begin
         int extra = 0;
         for (int i = 0; i < 20; i++) begin
            if (out_valid) extra++;
            @(posedge clk); #1;
         end
         check("single result", 32'(extra), 32'd0);
      end

      // Backpressure: result held stable while out_ready stays low
      issue(16'h3c00, 16'h4200, RNE);
      check("bp latency", 32'(lat), 32'(LatFull));
      for (int i = 0; i < 5; i++) begin
         check("bp result", 32'(result), 32'h3555);
         check("bp flags", 32'(flags), 32'h1);
         check("bp out_valid", 32'(out_valid), 32'd1);
         check("bp in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      drain("bp");

      // Reset in the middle of DIV
      x = 16'h3c00;
      y = 16'h4200;
      roundmode = RNE;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid div in_ready", 32'(in_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("post rst out_valid", 32'(out_valid), 32'd0);
      run_op("1/1 after rst", 16'h3c00, 16'h3c00, RNE, 16'h3c00, 4'b0000, LatOne);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
